// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Serialises one byte per request onto a single-wire UART line.
//   Frame: start (0), d0..d7 LSB first, optional parity, one stop (1).
//   Each bit is held on tx for CLKS_PER_BIT clocks.
//
// Ports
//   clk    in   system clock, all logic on posedge
//   reset  in   synchronous active-high reset
//   data   in   [7:0] byte to send, sampled only on the accepting edge
//   send   in   transmit request, level-sensitive, only looked at in IDLE
//   tx     out  serial line, idles high
//   busy   out  high while a frame is in progress
//   done   out  one-cycle pulse in the first IDLE cycle after a stop bit
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | line high, waiting for send
// START  | start bit (tx=0)
// DATA   | data bits, tx = shift[0], shift right at each bit boundary
// PARITY | parity bit (only when PARITY_EN)
// STOP   | stop bit (tx=1), then back to IDLE with a done pulse

module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic          tx_n, busy_n, done_n;
  logic          bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      par     <= par_n;
      tx      <= tx_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    par_n   = par;
    done_n  = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (send) begin
          shift_n = data;
          par_n   = (^data) ^ PARITY_ODD;
          state_n = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = S_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        bit_n   = '0;
        shift_n = '0;
        par_n   = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that the registered tx/busy
  // line up with the state register (tx low the cycle after acceptance).
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
//   Directed bench for uart_transmitter. Four instances cover the parameter
//   corners: default (even parity, 1 clk/bit), odd parity, no parity, and
//   4 clks/bit. Inputs are driven and outputs sampled on the falling edge.

module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic [3:0] send_v = 4'b0000;
  logic [3:0] tx_v, busy_v, done_v;

  int n_checks = 0;
  int n_fail   = 0;

  logic cap_tx   [0:63];
  logic cap_busy [0:63];
  logic cap_done [0:63];

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_def (
    .clk(clk), .reset(reset), .data(data), .send(send_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  uart_transmitter #(.CLKS_PER_BIT(1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .reset(reset), .data(data), .send(send_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  uart_transmitter #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_nopar (
    .clk(clk), .reset(reset), .data(data), .send(send_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_slow (
    .clk(clk), .reset(reset), .data(data), .send(send_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  // Expected 11-bit frame, index 0 = start bit, index 10 = stop bit.
  function automatic logic [10:0] frame11(input logic [7:0] b, input logic odd);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (^b) ^ odd;
    f[10]  = 1'b1;
    return f;
  endfunction

  task automatic start_frame(input int sel, input logic [7:0] b);
    @(negedge clk);
    data = b;
    send_v[sel] = 1'b1;
  endtask

  task automatic capture(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx[i]   = tx_v[sel];
      cap_busy[i] = busy_v[sel];
      cap_done[i] = done_v[sel];
      send_v[sel] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_v !== 4'hF) begin
      n_fail++; $display("FAIL reset_tx: got %b want 1111", tx_v);
    end
    n_checks++;
    if (busy_v !== 4'h0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0000", busy_v);
    end
    n_checks++;
    if (done_v !== 4'h0) begin
      n_fail++; $display("FAIL reset_done: got %b want 0000", done_v);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (tx_v !== 4'hF || busy_v !== 4'h0) begin
      n_fail++; $display("FAIL idle_hold: tx %b busy %b want 1111/0000", tx_v, busy_v);
    end
  endtask

  task automatic test_basic();
    logic [10:0] got;
    int nb, nd;
    start_frame(0, 8'hA5);
    capture(0, 14);
    for (int i = 0; i < 11; i++) got[i] = cap_tx[i];
    nb = 0; nd = 0;
    for (int i = 0; i < 14; i++) begin
      if (cap_busy[i] === 1'b1) nb++;
      if (cap_done[i] === 1'b1) nd++;
    end
    n_checks++;
    if (got !== 11'b10101001010) begin
      n_fail++; $display("FAIL basic_frame: got %b want 10101001010", got);
    end
    n_checks++;
    if (nb != 11 || cap_busy[0] !== 1'b1 || cap_busy[10] !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: busy cycles %0d want 11", nb);
    end
    n_checks++;
    if (cap_done[11] !== 1'b1 || nd != 1) begin
      n_fail++; $display("FAIL basic_done: done@11=%b pulses %0d want 1/1", cap_done[11], nd);
    end
  endtask

  task automatic test_parity();
    logic [10:0] got;
    logic [9:0]  got10;
    int nb;
    start_frame(0, 8'h01);
    capture(0, 13);
    for (int i = 0; i < 11; i++) got[i] = cap_tx[i];
    n_checks++;
    if (cap_tx[9] !== 1'b1 || got !== 11'b11000000010) begin
      n_fail++; $display("FAIL parity_even: frame %b want 11000000010", got);
    end

    start_frame(1, 8'h01);
    capture(1, 13);
    for (int i = 0; i < 11; i++) got[i] = cap_tx[i];
    n_checks++;
    if (cap_tx[9] !== 1'b0 || got !== 11'b10000000010) begin
      n_fail++; $display("FAIL parity_odd: frame %b want 10000000010", got);
    end

    start_frame(2, 8'hFF);
    capture(2, 13);
    for (int i = 0; i < 10; i++) got10[i] = cap_tx[i];
    nb = 0;
    for (int i = 0; i < 13; i++) if (cap_busy[i] === 1'b1) nb++;
    n_checks++;
    if (got10 !== 10'b1111111110) begin
      n_fail++; $display("FAIL noparity_frame: got %b want 1111111110", got10);
    end
    n_checks++;
    if (nb != 10 || cap_done[10] !== 1'b1) begin
      n_fail++; $display("FAIL noparity_len: busy %0d done@10=%b want 10/1", nb, cap_done[10]);
    end
  endtask

  task automatic test_baud();
    logic [10:0] f;
    int mism, nb;
    f = frame11(8'h3C, 1'b0);
    start_frame(3, 8'h3C);
    capture(3, 50);
    mism = 0; nb = 0;
    for (int k = 0; k < 11; k++)
      for (int j = 0; j < 4; j++)
        if (cap_tx[4*k+j] !== f[k]) mism++;
    for (int i = 0; i < 50; i++) if (cap_busy[i] === 1'b1) nb++;
    n_checks++;
    if (mism != 0) begin
      n_fail++; $display("FAIL baud_bits: %0d cycles differ want 0", mism);
    end
    n_checks++;
    if (nb != 44) begin
      n_fail++; $display("FAIL baud_busy: busy cycles %0d want 44", nb);
    end
    n_checks++;
    if (cap_done[44] !== 1'b1 || cap_done[43] !== 1'b0 || cap_tx[44] !== 1'b1) begin
      n_fail++; $display("FAIL baud_done: done@43=%b done@44=%b want 0/1", cap_done[43], cap_done[44]);
    end
  endtask

  task automatic test_ignore_busy();
    logic [10:0] got;
    int nd, bad_tail;
    start_frame(0, 8'h11);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cap_tx[i]   = tx_v[0];
      cap_busy[i] = busy_v[0];
      cap_done[i] = done_v[0];
      if (i == 0) send_v[0] = 1'b0;
      if (i == 4) begin data = 8'hEE; send_v[0] = 1'b1; end
      if (i == 5) send_v[0] = 1'b0;
    end
    for (int i = 0; i < 11; i++) got[i] = cap_tx[i];
    nd = 0; bad_tail = 0;
    for (int i = 0; i < 16; i++) if (cap_done[i] === 1'b1) nd++;
    for (int i = 12; i < 16; i++) if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) bad_tail++;
    n_checks++;
    if (got !== 11'b10000100010) begin
      n_fail++; $display("FAIL ignore_frame: got %b want 10000100010", got);
    end
    n_checks++;
    if (nd != 1 || bad_tail != 0) begin
      n_fail++; $display("FAIL ignore_nosecond: done pulses %0d bad idle %0d want 1/0", nd, bad_tail);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] g1, g2;
    int nd;
    start_frame(0, 8'h80);
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      cap_tx[i]   = tx_v[0];
      cap_busy[i] = busy_v[0];
      cap_done[i] = done_v[0];
      if (i == 0)  data = 8'h7F;
      if (i == 12) send_v[0] = 1'b0;
    end
    for (int i = 0; i < 11; i++) begin
      g1[i] = cap_tx[i];
      g2[i] = cap_tx[12+i];
    end
    nd = 0;
    for (int i = 0; i < 26; i++) if (cap_done[i] === 1'b1) nd++;
    n_checks++;
    if (g1 !== 11'b11100000000) begin
      n_fail++; $display("FAIL b2b_frame1: got %b want 11100000000", g1);
    end
    n_checks++;
    if (cap_tx[11] !== 1'b1 || cap_busy[11] !== 1'b0 || cap_done[11] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap: tx %b busy %b done %b want 1/0/1", cap_tx[11], cap_busy[11], cap_done[11]);
    end
    n_checks++;
    if (g2 !== 11'b11011111110) begin
      n_fail++; $display("FAIL b2b_frame2: got %b want 11011111110", g2);
    end
    n_checks++;
    if (nd != 2 || cap_done[23] !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done: pulses %0d done@23=%b want 2/1", nd, cap_done[23]);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] f;
    int nd, nlow, mism;
    start_frame(3, 8'h5A);
    capture(3, 18);
    n_checks++;
    if (cap_tx[16] !== 1'b1 || cap_tx[12] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_pre: d2=%b d3=%b want 0/1", cap_tx[12], cap_tx[16]);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_v[3] !== 1'b1 || busy_v[3] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_abort: tx %b busy %b want 1/0", tx_v[3], busy_v[3]);
    end
    reset = 1'b0;
    nd = 0; nlow = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_v[3] === 1'b1) nd++;
      if (tx_v[3] !== 1'b1) nlow++;
    end
    n_checks++;
    if (nd != 0 || nlow != 0) begin
      n_fail++; $display("FAIL rstmid_quiet: done pulses %0d tx low %0d want 0/0", nd, nlow);
    end
    f = frame11(8'h01, 1'b0);
    start_frame(3, 8'h01);
    capture(3, 46);
    mism = 0;
    for (int k = 0; k < 11; k++)
      for (int j = 0; j < 4; j++)
        if (cap_tx[4*k+j] !== f[k]) mism++;
    n_checks++;
    if (mism != 0 || cap_done[44] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_recover: %0d cycles differ done@44=%b want 0/1", mism, cap_done[44]);
    end
  endtask

  // Mid-bit sampling receiver on the 4-clk/bit instance.
  task automatic rx_check(input logic [7:0] b);
    logic [7:0] rxb;
    logic       err, found;
    rxb = 8'h00;
    err = 1'b0;
    found = 1'b0;
    start_frame(3, b);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      send_v[3] = 1'b0;
      if (tx_v[3] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL loopback_start: no start bit within 20 cycles for %h", b);
    end else begin
      repeat (2) @(negedge clk);
      if (tx_v[3] !== 1'b0) err = 1'b1;
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(negedge clk);
        rxb[k] = tx_v[3];
      end
      repeat (4) @(negedge clk);
      if (tx_v[3] !== (^rxb)) err = 1'b1;
      repeat (4) @(negedge clk);
      if (tx_v[3] !== 1'b1) err = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (rxb !== b || err !== 1'b0) begin
        n_fail++; $display("FAIL loopback: rx %h err %b want %h/0", rxb, err, b);
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] vec [4];
    vec[0] = 8'h00;
    vec[1] = 8'hFF;
    vec[2] = 8'hA5;
    vec[3] = 8'h3C;
    for (int i = 0; i < 4; i++) rx_check(vec[i]);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_baud();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
